// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants and bus layouts shared by the pipeline stages.
//   FS_TO_DS_BUS_WD : width of the fetch -> decode bus {inst, pc}
//   BR_BUS_WD       : width of the decode -> fetch branch bus {taken, target}
//   RESET_PC_DEFAULT: address of the first instruction fetched after reset
package cpu_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int BR_BUS_WD       = 33;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  // Sequential successor; plain 32-bit add, so 0xfffffffc wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if -- signals between the fetch stage, the decode stage and the
// instruction SRAM.
//   master : the fetch stage (drives fs_to_ds_*, inst_sram_* requests)
//   slave  : the environment (decode + SRAM)
interface if_stage_if;
  import cpu_pkg::*;

  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_en;
  logic                       inst_sram_we;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic [31:0]                inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

endinterface

// File: rtl/if_inst_buf.sv
// if_inst_buf -- one-word instruction holding buffer for the fetch stage.
// Captures the SRAM read data on the first stalled cycle so the SRAM can be
// idled for the rest of the stall.
//   clk, reset : clock, synchronous active-high reset
//   stall      : fetch slot is valid and decode refuses it
//   advance    : fetch slot moves on this cycle
//   sram_rdata : instruction SRAM read data
//   inst       : instruction for the current slot (buffer or live data)
//   buf_valid  : buffer holds the instruction of the current slot
module if_inst_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        advance,
  input  logic [31:0] sram_rdata,
  output logic [31:0] inst,
  output logic        buf_valid
);

  logic [31:0] buf_data;

  // NOTE: the data register is reset too, so a stale word never survives a
  // reset; it is a single word, not an array, so this costs nothing notable.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (advance) begin
      buf_valid <= 1'b0;
    end else if (stall && !buf_valid) begin
      buf_valid <= 1'b1;
      buf_data  <= sram_rdata;
    end
  end

  assign inst = buf_valid ? buf_data : sram_rdata;

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage of the pipeline.
// Holds one fetch slot {fs_pc, fs_inst}; issues the next SRAM read with the
// PC it will move to, so the data lands in the slot one cycle later.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : if_stage_if.master -- ds_allowin, br_bus in; fs_to_ds_valid,
//           fs_to_ds_bus out; inst_sram_{en,we,addr,wdata} out, rdata in
// Build option: define IF_INST_BUF_EN to latch the stalled instruction in
// if_inst_buf and turn the SRAM off for the rest of a stall; otherwise the
// same word is re-read every stalled cycle.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.master bus
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fetch_en;
  br_bus_t     br;
  fs_to_ds_t   fs_to_ds;

  assign br          = bus.br_bus;
  assign seq_pc      = pc_plus4(fs_pc);
  assign nextpc      = br.taken ? br.target : seq_pc;
  assign fs_ready_go = 1'b1;
  assign fs_allowin  = !fs_valid || (fs_ready_go && bus.ds_allowin);

  // Reset value is RESET_PC-4 so the first nextpc is RESET_PC.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (fs_allowin) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end
  end

`ifdef IF_INST_BUF_EN
  logic buf_valid;

  if_inst_buf u_inst_buf (
    .clk        (clk),
    .reset      (reset),
    .stall      (fs_valid && !bus.ds_allowin),
    .advance    (fs_allowin),
    .sram_rdata (bus.inst_sram_rdata),
    .inst       (fs_inst),
    .buf_valid  (buf_valid)
  );

  // Once the stalled word is held, the SRAM can stay idle until the slot moves.
  assign fetch_en = fs_allowin || !buf_valid;
`else
  assign fs_inst  = bus.inst_sram_rdata;
  // Stalled cycles re-read fs_pc, keeping rdata equal to the slot's word.
  assign fetch_en = 1'b1;
`endif

  assign bus.inst_sram_en    = !reset && fetch_en;
  assign bus.inst_sram_addr  = fs_allowin ? nextpc : fs_pc;
  assign bus.inst_sram_we    = 1'b0;
  assign bus.inst_sram_wdata = '0;

  // A taken branch means the slot holds a wrong-path instruction.
  assign fs_to_ds.inst      = fs_inst;
  assign fs_to_ds.pc        = fs_pc;
  assign bus.fs_to_ds_bus   = fs_to_ds;
  assign bus.fs_to_ds_valid = fs_valid && fs_ready_go && !br.taken && !reset;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- self-checking bench for if_stage: a directed vector table
// covering reset release, stalls, branches, reset mid-stall and PC wrap,
// followed by randomized traffic checked against a slot-level model.
module tb_if_stage;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;
`ifdef IF_INST_BUF_EN
  localparam bit STALL_EN = 1'b0;
`else
  localparam bit STALL_EN = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c00_0008) return 32'h0280_0421;
    return (a * 32'h9e37_79b1) ^ 32'h5a5a_5a5a;
  endfunction

  // SRAM with one-cycle read latency; output is junk when not enabled, so a
  // design relying on stale data is caught.
  always @(posedge clk) begin
    if (bus.inst_sram_en) bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
    else                  bus.inst_sram_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic al, input logic bt,
                       input logic [31:0] tgt);
    @(negedge clk);
    reset          = r;
    bus.ds_allowin = al;
    bus.br_bus     = {bt, tgt};
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        al;
    logic        bt;
    logic [31:0] tgt;
    logic        ev;    // expected fs_to_ds_valid
    logic [31:0] epc;   // expected pc when ev
    logic        een;   // expected inst_sram_en
    logic [31:0] eaddr; // expected inst_sram_addr when een
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic al, input logic bt,
                     input logic [31:0] tgt, input logic ev,
                     input logic [31:0] epc, input logic een,
                     input logic [31:0] eaddr);
    vec_t v;
    v = '{rst, al, bt, tgt, ev, epc, een, eaddr};
    vecs.push_back(v);
  endtask

  // Model of the fetch slot: which pc it holds and whether it is valid.
  logic        m_valid;
  logic [31:0] m_pc;
  int          stall_run;
  logic        hold_br;

  initial begin
    reset          = 1'b1;
    bus.ds_allowin = 1'b1;
    bus.br_bus     = '0;

    // rst al bt target       ev pc            en        addr
    add(1, 1, 0, 0,            0, 0,            0,        0);
    add(1, 1, 0, 0,            0, 0,            0,        0);
    add(0, 1, 0, 0,            0, 0,            1,        32'h1c00_0000);
    add(0, 1, 0, 0,            1, 32'h1c00_0000, 1,       32'h1c00_0004);
    add(0, 1, 0, 0,            1, 32'h1c00_0004, 1,       32'h1c00_0008);
    add(0, 0, 0, 0,            1, 32'h1c00_0008, 1,       32'h1c00_0008);
    add(0, 0, 0, 0,            1, 32'h1c00_0008, STALL_EN, 32'h1c00_0008);
    add(0, 0, 0, 0,            1, 32'h1c00_0008, STALL_EN, 32'h1c00_0008);
    add(0, 1, 0, 0,            1, 32'h1c00_0008, 1,       32'h1c00_000c);
    add(0, 1, 0, 0,            1, 32'h1c00_000c, 1,       32'h1c00_0010);
    add(0, 1, 1, 32'h1c00_0100, 0, 0,            1,       32'h1c00_0100);
    add(0, 1, 0, 0,            1, 32'h1c00_0100, 1,       32'h1c00_0104);
    add(0, 0, 1, 32'h1c00_0200, 0, 0,            1,       32'h1c00_0104);
    add(0, 0, 1, 32'h1c00_0200, 0, 0,            STALL_EN, 32'h1c00_0104);
    add(0, 1, 1, 32'h1c00_0200, 0, 0,            1,       32'h1c00_0200);
    add(0, 1, 0, 0,            1, 32'h1c00_0200, 1,       32'h1c00_0204);
    add(0, 0, 0, 0,            1, 32'h1c00_0204, 1,       32'h1c00_0204);
    add(1, 0, 0, 0,            0, 0,            0,        0);
    add(0, 0, 0, 0,            0, 0,            1,        32'h1c00_0000);
    add(0, 1, 0, 0,            1, 32'h1c00_0000, 1,       32'h1c00_0004);
    add(0, 1, 1, 32'hffff_fffc, 0, 0,           1,        32'hffff_fffc);
    add(0, 1, 0, 0,            1, 32'hffff_fffc, 1,       32'h0000_0000);
    add(0, 1, 0, 0,            1, 32'h0000_0000, 1,       32'h0000_0004);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].al, vecs[i].bt, vecs[i].tgt);
      check($sformatf("v%0d_valid", i), {31'd0, bus.fs_to_ds_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d_en", i), {31'd0, bus.inst_sram_en}, {31'd0, vecs[i].een});
      if (vecs[i].ev) begin
        check($sformatf("v%0d_pc", i), bus.fs_to_ds_bus[31:0], vecs[i].epc);
        check($sformatf("v%0d_inst", i), bus.fs_to_ds_bus[63:32], mem_word(vecs[i].epc));
      end
      if (vecs[i].een)
        check($sformatf("v%0d_addr", i), bus.inst_sram_addr, vecs[i].eaddr);
    end
    check("sram_we", {31'd0, bus.inst_sram_we}, 32'd0);
    check("sram_wdata", bus.inst_sram_wdata, 32'd0);

    // Randomized phase; starts from a reset so the model is in step.
    m_valid   = 1'b0;
    m_pc      = RST_PC - 32'd4;
    stall_run = 0;
    hold_br   = 1'b0;
    drive(1, 1, 0, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r, al, bt, fs_take;
      logic [31:0] tgt, want_next;
      r  = ($urandom_range(63) == 0);
      al = ($urandom_range(3) != 0);
      if (hold_br) begin
        // Decode keeps a stalled branch on br_bus unchanged.
        bt  = bus.br_bus[32];
        tgt = bus.br_bus[31:0];
      end else begin
        bt  = ($urandom_range(5) == 0);
        tgt = {16'h1c00, 14'($urandom), 2'b00};
      end
      drive(r, al, bt, tgt);

      fs_take   = !m_valid || al;
      want_next = bt ? tgt : m_pc + 32'd4;

      check($sformatf("r%0d_valid", cyc), {31'd0, bus.fs_to_ds_valid},
            {31'd0, !r && m_valid && !bt});
      if (!r && m_valid && !bt) begin
        check($sformatf("r%0d_pc", cyc), bus.fs_to_ds_bus[31:0], m_pc);
        check($sformatf("r%0d_inst", cyc), bus.fs_to_ds_bus[63:32], mem_word(m_pc));
      end
      if (r) begin
        check($sformatf("r%0d_en", cyc), {31'd0, bus.inst_sram_en}, 32'd0);
      end else if (fs_take) begin
        check($sformatf("r%0d_en", cyc), {31'd0, bus.inst_sram_en}, 32'd1);
        check($sformatf("r%0d_addr", cyc), bus.inst_sram_addr, want_next);
      end else begin
        check($sformatf("r%0d_en", cyc), {31'd0, bus.inst_sram_en},
              {31'd0, STALL_EN || (stall_run == 0)});
        if (bus.inst_sram_en)
          check($sformatf("r%0d_addr", cyc), bus.inst_sram_addr, m_pc);
      end

      // Advance the model across the coming clock edge.
      hold_br = !r && bt && m_valid && !al;
      if (r) begin
        m_valid   = 1'b0;
        m_pc      = RST_PC - 32'd4;
        stall_run = 0;
      end else if (fs_take) begin
        m_valid   = 1'b1;
        m_pc      = want_next;
        stall_run = 0;
      end else begin
        stall_run++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
